// File: rtl/i2c_pkg.sv
// Shared types and elaboration-time helpers for the I2C clock/bit blocks.
// The cycle math is done in 64 bits because CLK_HZ*LOW_PCT overflows 32 bits.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HWAIT = 2'd2,
        HIGH  = 2'd3
    } scl_state_t;

    // Truncating clk_hz*pct/(scl_hz*100); pct=100 gives the full period.
    function automatic logic [63:0] cyc_calc(
        input logic [63:0] clk_hz,
        input logic [63:0] scl_hz,
        input logic [63:0] pct
    );
        return (clk_hz * pct) / (scl_hz * 64'd100);
    endfunction

    function automatic logic [63:0] max3(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] c
    );
        logic [63:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for the open-drain bus inputs (SCL, SDA).
// Resets to 1 so that a released bus reads idle straight out of reset.
module i2c_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/i2c_scl_gen.sv
// Parametrised SCL generator with slave clock stretching, stretch timeout and
// per-phase strobes for the bit FSM. Outputs are registered from next-state.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 156_250_000,
    parameter int unsigned SCL_HZ      = 100_000,
    parameter int unsigned LOW_PCT     = 50,
    parameter int unsigned STRETCH_MAX = 156_250
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic en,
    input  logic scl_i,
    output logic scl_t,
    output logic busy,
    output logic fall_stb,
    output logic mid_low_stb,
    output logic mid_high_stb,
    output logic bit_done,
    output logic stretching,
    output logic stretch_err
);

    localparam logic [63:0] TOT_CYC  = cyc_calc(64'(CLK_HZ), 64'(SCL_HZ), 64'd100);
    localparam logic [63:0] LOW_CYC  = cyc_calc(64'(CLK_HZ), 64'(SCL_HZ), 64'(LOW_PCT));
    localparam logic [63:0] HIGH_CYC = TOT_CYC - LOW_CYC;
    localparam int          CNT_W    = $clog2(max3(LOW_CYC, HIGH_CYC, 64'(STRETCH_MAX)) + 64'd1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYC - 64'd1);
    localparam logic [CNT_W-1:0] LOW_MID   = CNT_W'(LOW_CYC / 64'd2);
    // HWAIT already contributes 3 released cycles, so HIGH itself is 3 shorter.
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYC - 64'd4);
    localparam logic [CNT_W-1:0] HIGH_MID  = CNT_W'((HIGH_CYC - 64'd3) / 64'd2);
    localparam logic [CNT_W-1:0] STR_LIM   = CNT_W'(STRETCH_MAX);
    localparam logic [CNT_W-1:0] STR_SHOW  = CNT_W'(3);

    if (LOW_CYC < 64'd4 || HIGH_CYC < 64'd8) begin : g_bad_timing
        $error("i2c_scl_gen: LOW_CYC=%0d HIGH_CYC=%0d too short for this CLK/SCL ratio",
               LOW_CYC, HIGH_CYC);
    end
    if (LOW_PCT < 1 || LOW_PCT > 99) begin : g_bad_pct
        $error("i2c_scl_gen: LOW_PCT=%0d outside 1..99", LOW_PCT);
    end

    logic scl_s;

    i2c_sync2 #(
        .WIDTH(1)
    ) u_scl_sync (
        .clk  (CLK),
        .rst_n(rst_n),
        .d    (scl_i),
        .q    (scl_s)
    );

    scl_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_lock_reg, err_lock_next;
    logic             timeout;

    logic scl_t_reg, scl_t_next;
    logic busy_reg, busy_next;
    logic fall_stb_reg, fall_stb_next;
    logic mid_low_stb_reg, mid_low_stb_next;
    logic mid_high_stb_reg, mid_high_stb_next;
    logic bit_done_reg, bit_done_next;
    logic stretching_reg, stretching_next;
    logic stretch_err_reg, stretch_err_next;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        err_lock_next = err_lock_reg;
        timeout       = 1'b0;

        if (!en) begin
            err_lock_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (en && !err_lock_reg) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (cnt_reg == LOW_LAST) begin
                    state_next = HWAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            HWAIT: begin
                // A release seen on the timeout cycle still wins.
                if (scl_s) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == STR_LIM) begin
                    timeout       = 1'b1;
                    state_next    = IDLE;
                    cnt_next      = '0;
                    err_lock_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt_reg == HIGH_LAST) begin
                    cnt_next   = '0;
                    state_next = en ? LOW : IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        scl_t_next        = (state_next != LOW);
        busy_next         = (state_next != IDLE);
        fall_stb_next     = (state_next == LOW)  && (cnt_next == '0);
        mid_low_stb_next  = (state_next == LOW)  && (cnt_next == LOW_MID);
        mid_high_stb_next = (state_next == HIGH) && (cnt_next == HIGH_MID);
        bit_done_next     = (state_next == HIGH) && (cnt_next == HIGH_LAST);
        // Only counts past the 3-cycle sync latency are a real stretch.
        stretching_next   = (state_next == HWAIT) && (cnt_next >= STR_SHOW);
        stretch_err_next  = timeout;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            err_lock_reg     <= 1'b0;
            scl_t_reg        <= 1'b1;
            busy_reg         <= 1'b0;
            fall_stb_reg     <= 1'b0;
            mid_low_stb_reg  <= 1'b0;
            mid_high_stb_reg <= 1'b0;
            bit_done_reg     <= 1'b0;
            stretching_reg   <= 1'b0;
            stretch_err_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            err_lock_reg     <= err_lock_next;
            scl_t_reg        <= scl_t_next;
            busy_reg         <= busy_next;
            fall_stb_reg     <= fall_stb_next;
            mid_low_stb_reg  <= mid_low_stb_next;
            mid_high_stb_reg <= mid_high_stb_next;
            bit_done_reg     <= bit_done_next;
            stretching_reg   <= stretching_next;
            stretch_err_reg  <= stretch_err_next;
        end
    end

    assign scl_t        = scl_t_reg;
    assign busy         = busy_reg;
    assign fall_stb     = fall_stb_reg;
    assign mid_low_stb  = mid_low_stb_reg;
    assign mid_high_stb = mid_high_stb_reg;
    assign bit_done     = bit_done_reg;
    assign stretching   = stretching_reg;
    assign stretch_err  = stretch_err_reg;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Scoreboard bench: one default DUT (100 kHz) and one small DUT (1 MHz/50 kHz,
// 30 % low, STRETCH_MAX=50); per-bit phase timings are checked against a queue.
module tb_i2c_scl_gen;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_n, en_a, en_b, hold_a, hold_b;
    logic a_scl_i, a_scl_t, a_busy, a_fall, a_ml, a_mh, a_bd, a_str, a_err;
    logic b_scl_i, b_scl_t, b_busy, b_fall, b_ml, b_mh, b_bd, b_str, b_err;

    // Loopback through the pad; hold_* models a slave pulling SCL low.
    assign a_scl_i = a_scl_t & ~hold_a;
    assign b_scl_i = b_scl_t & ~hold_b;

    i2c_scl_gen dut_a (
        .CLK(CLK), .rst_n(rst_n), .en(en_a), .scl_i(a_scl_i), .scl_t(a_scl_t),
        .busy(a_busy), .fall_stb(a_fall), .mid_low_stb(a_ml), .mid_high_stb(a_mh),
        .bit_done(a_bd), .stretching(a_str), .stretch_err(a_err)
    );

    i2c_scl_gen #(
        .CLK_HZ(1_000_000), .SCL_HZ(50_000), .LOW_PCT(30), .STRETCH_MAX(50)
    ) dut_b (
        .CLK(CLK), .rst_n(rst_n), .en(en_b), .scl_i(b_scl_i), .scl_t(b_scl_t),
        .busy(b_busy), .fall_stb(b_fall), .mid_low_stb(b_ml), .mid_high_stb(b_mh),
        .bit_done(b_bd), .stretching(b_str), .stretch_err(b_err)
    );

    logic [7:0] out_a, out_b;
    logic [1:0] scl_t_w;
    assign out_a   = {a_scl_t, a_busy, a_fall, a_ml, a_mh, a_bd, a_str, a_err};
    assign out_b   = {b_scl_t, b_busy, b_fall, b_ml, b_mh, b_bd, b_str, b_err};
    assign scl_t_w = {b_scl_t, a_scl_t};

    typedef struct {
        int dut;
        int low_len;
        int high_len;
        int fall_pos;
        int ml_pos;
        int mh_pos;
        int stretched;
    } bit_rec_t;

    bit_rec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Default DUT: low 781, high 781 (3 HWAIT + 778 HIGH); small DUT: low 6, high 14.
    function automatic bit_rec_t rec_a(input int stretch_cyc);
        bit_rec_t r;
        r.dut       = 0;
        r.low_len   = 781;
        r.high_len  = 781 + stretch_cyc;
        r.fall_pos  = 0;
        r.ml_pos    = 390;
        r.mh_pos    = 3 + stretch_cyc + 389;
        r.stretched = (stretch_cyc > 0) ? 1 : 0;
        return r;
    endfunction

    function automatic bit_rec_t rec_b();
        bit_rec_t r;
        r.dut       = 1;
        r.low_len   = 6;
        r.high_len  = 14;
        r.fall_pos  = 0;
        r.ml_pos    = 3;
        r.mh_pos    = 3 + 5;
        r.stretched = 0;
        return r;
    endfunction

    int   low_cnt[2], high_cnt[2], fall_pos[2], ml_pos[2], mh_pos[2], saw_str[2];
    int   fall_tot[2], err_tot[2], str_tot[2];
    logic prev_t[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_t[i] = 1'b1; fall_tot[i] = 0; err_tot[i] = 0; str_tot[i] = 0;
            low_cnt[i] = 0; high_cnt[i] = 0; fall_pos[i] = -1; ml_pos[i] = -1;
            mh_pos[i] = -1; saw_str[i] = 0;
        end
    end

    task automatic mon_step(input int k, input logic [7:0] o);
        bit_rec_t e;
        if (o[5]) fall_tot[k]++;
        if (o[0]) err_tot[k]++;
        if (o[1]) str_tot[k]++;
        if (!o[7]) begin
            if (prev_t[k]) begin
                low_cnt[k] = 0; high_cnt[k] = 0; fall_pos[k] = -1;
                ml_pos[k] = -1; mh_pos[k] = -1; saw_str[k] = 0;
            end
            if (o[5]) fall_pos[k] = low_cnt[k];
            if (o[4]) ml_pos[k] = low_cnt[k];
            low_cnt[k]++;
        end else begin
            if (o[3]) mh_pos[k] = high_cnt[k];
            if (o[1]) saw_str[k] = 1;
            high_cnt[k]++;
            if (o[2]) begin
                $display("bit dut%0d low=%0d high=%0d fall@%0d mid_low@%0d mid_high@%0d stretched=%0d",
                         k, low_cnt[k], high_cnt[k], fall_pos[k], ml_pos[k], mh_pos[k], saw_str[k]);
                chk("bit_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("bit_dut", k, e.dut);
                    chk("low_len", low_cnt[k], e.low_len);
                    chk("high_len", high_cnt[k], e.high_len);
                    chk("fall_pos", fall_pos[k], e.fall_pos);
                    chk("mid_low_pos", ml_pos[k], e.ml_pos);
                    chk("mid_high_pos", mh_pos[k], e.mh_pos);
                    chk("stretched", saw_str[k], e.stretched);
                end
            end
        end
        prev_t[k] = o[7];
    endtask

    always @(negedge CLK) begin
        mon_step(0, out_a);
        mon_step(1, out_b);
    end

    task automatic wait_q(input int n, input int max_cyc, input string tag);
        int c = 0;
        while (exp_q.size() != n && c < max_cyc) begin
            @(posedge CLK); #1;
            c++;
        end
        chk(tag, exp_q.size(), n);
    endtask

    task automatic wait_lvl(input int k, input logic lvl, input int max_cyc, input string tag);
        int c = 0;
        while (scl_t_w[k] !== lvl && c < max_cyc) begin
            @(posedge CLK); #1;
            c++;
        end
        chk(tag, scl_t_w[k], lvl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_a", out_a, 8'h80);
        chk("reset_b", out_b, 8'h80);
        rst_n = 1'b1;

        // Three plain bits, one stretched by 1000 cycles, one ended by dropping en.
        for (int i = 0; i < 3; i++) exp_q.push_back(rec_a(0));
        exp_q.push_back(rec_a(1000));
        exp_q.push_back(rec_a(0));
        en_a = 1'b1;
        wait_q(2, 3 * 1600 + 100, "t1_three_bits");
        hold_a = 1'b1;
        wait_lvl(0, 1'b1, 1000, "t3_release");
        repeat (1000) @(posedge CLK);
        #1;
        hold_a = 1'b0;
        wait_q(1, 2000, "t3_stretched_bit");
        repeat (100) @(posedge CLK);
        #1;
        en_a = 1'b0;
        wait_q(0, 2000, "t5_last_bit");
        chk("t5_idle_next_cycle", {a_scl_t, a_busy}, 2'b10);
        repeat (2000) @(posedge CLK);
        #1;
        chk("t5_no_restart", fall_tot[0], 5);
        chk("t3_no_stretch_err", err_tot[0], 0);

        // Reset in the middle of HIGH, then in the middle of HWAIT.
        en_a = 1'b1;
        wait_lvl(0, 1'b0, 100, "t6_start");
        wait_lvl(0, 1'b1, 1000, "t6_rise");
        repeat (100) @(posedge CLK);
        #1;
        rst_n = 1'b0;
        @(posedge CLK); #1;
        chk("t6_reset_mid_high", out_a, 8'h80);
        rst_n = 1'b1;
        @(posedge CLK); #1;
        chk("t6_restart_fall_1", {a_fall, a_scl_t}, 2'b10);
        wait_lvl(0, 1'b1, 1000, "t6_rise_2");
        rst_n = 1'b0;
        @(posedge CLK); #1;
        chk("t6_reset_mid_hwait", out_a, 8'h80);
        rst_n = 1'b1;
        exp_q.push_back(rec_a(0));
        @(posedge CLK); #1;
        chk("t6_restart_fall_2", {a_fall, a_scl_t}, 2'b10);
        repeat (50) @(posedge CLK);
        #1;
        en_a = 1'b0;
        wait_q(0, 2000, "t6_bit_after_reset");

        // Small DUT: three looped-back bits (period 20).
        for (int i = 0; i < 3; i++) exp_q.push_back(rec_b());
        en_b = 1'b1;
        wait_q(1, 200, "t2_two_bits");
        en_b = 1'b0;
        wait_q(0, 100, "t2_third_bit");

        // Slave holds SCL low forever: timeout after STRETCH_MAX+1 HWAIT cycles.
        hold_b = 1'b1;
        en_b = 1'b1;
        wait_lvl(1, 1'b0, 20, "t4_low");
        wait_lvl(1, 1'b1, 50, "t4_release");
        c = 0;
        while (b_err !== 1'b1 && c < 200) begin
            @(posedge CLK); #1;
            c++;
        end
        chk("t4_timeout_cycles", c, 51);
        chk("t4_idle_at_err", {b_scl_t, b_busy}, 2'b10);
        @(posedge CLK); #1;
        chk("t4_err_pulse_then_idle", out_b, 8'h80);
        hold_b = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        chk("t4_locked_idle", {b_scl_t, b_busy}, 2'b10);
        chk("t4_err_count", err_tot[1], 1);
        chk("t4_stretching_seen", str_tot[1] > 0, 1);
        en_b = 1'b0;
        @(posedge CLK); #1;
        en_b = 1'b1;
        exp_q.push_back(rec_b());
        wait_lvl(1, 1'b0, 10, "t4_restart");
        chk("t4_restart_fall", b_fall, 1'b1);
        en_b = 1'b0;
        wait_q(0, 100, "t4_bit_after_unlock");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
